// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving active-low seven-segment digits,
// with optional leading-zero blanking and all-nines saturation on overflow.
module bcd_display_driver #(
  parameter int unsigned BIN_W         = 4,
  parameter int unsigned DIGITS        = 2,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      value,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int unsigned SR_W    = 4 * DIGITS + BIN_W;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned CMP_W   = (BIN_W > 4 * DIGITS) ? BIN_W : 4 * DIGITS;
  localparam int unsigned MAX_DEC = 10 ** DIGITS - 1;
  // When every representable input fits in DIGITS decimal digits, overflow can never occur.
  localparam bit OVF_POSSIBLE = (MAX_DEC < (2 ** BIN_W - 1));
  localparam logic [CMP_W-1:0] MAX_DEC_C = CMP_W'(MAX_DEC);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [SR_W-1:0]       shreg_q, shreg_d, shreg_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d, bcd_new;
  logic [7*DIGITS-1:0]   seg_q, seg_d, seg_new;
  logic [3:0]            nib;
  logic                  lead_zero;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on every BCD nibble ahead of the shift.
  always_comb begin
    shreg_adj = shreg_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (shreg_q[BIN_W + 4*d +: 4] >= 4'd5) begin
        shreg_adj[BIN_W + 4*d +: 4] = shreg_q[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  // Digit values and segment patterns presented when the conversion completes.
  always_comb begin
    bcd_new   = ovf_pend_q ? {DIGITS{4'h9}} : shreg_q[SR_W-1 -: 4*DIGITS];
    seg_new   = '1;
    nib       = '0;
    lead_zero = 1'b1;
    for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
      nib = bcd_new[4*d +: 4];
      if (BLANK_LEADING != 0 && lead_zero && nib == 4'd0 && d != 0) begin
        seg_new[7*d +: 7] = 7'b1111111;
      end else begin
        seg_new[7*d +: 7] = seg7(nib);
      end
      if (nib != 4'd0) lead_zero = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    seg_d      = seg_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shreg_d    = SR_W'(value);
          ovf_pend_d = OVF_POSSIBLE && (CMP_W'(value) > MAX_DEC_C);
          cnt_d      = CNT_W'(BIN_W);
          state_d    = StShift;
        end
      end
      StShift: begin
        shreg_d = shreg_adj << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StDone;
      end
      StDone: begin
        bcd_d   = bcd_new;
        seg_d   = seg_new;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      seg_q      <= '1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Randomised bench for bcd_display_driver: four parameterisations checked against an
// arithmetic decimal/segment reference model.
module tb_bcd_display_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [13:0] vin;
  logic [3:0]  ld;
  logic [3:0]  busy_w, done_w, ovf_w;
  logic [7:0]  bcd4, bcd4n, bcd7;
  logic [15:0] bcd14;
  logic [13:0] seg4, seg4n, seg7w;
  logic [27:0] seg14;

  int          sel;
  logic [19:0] obs_bcd;
  logic [34:0] obs_seg;
  logic        done_s, busy_s, ovf_s;

  int errors;
  int checks;

  int bw_tab[4] = '{4, 4, 7, 14};
  int nd_tab[4] = '{2, 2, 2, 4};
  int bl_tab[4] = '{1, 0, 1, 1};

  always #5 clock = ~clock;

  bcd_display_driver #(.BIN_W(4), .DIGITS(2), .BLANK_LEADING(1)) u4 (
    .clock(clock), .reset(reset), .value(vin[3:0]), .load(ld[0]), .busy(busy_w[0]),
    .done(done_w[0]), .overflow(ovf_w[0]), .bcd(bcd4), .segments(seg4));
  bcd_display_driver #(.BIN_W(4), .DIGITS(2), .BLANK_LEADING(0)) u4n (
    .clock(clock), .reset(reset), .value(vin[3:0]), .load(ld[1]), .busy(busy_w[1]),
    .done(done_w[1]), .overflow(ovf_w[1]), .bcd(bcd4n), .segments(seg4n));
  bcd_display_driver #(.BIN_W(7), .DIGITS(2), .BLANK_LEADING(1)) u7 (
    .clock(clock), .reset(reset), .value(vin[6:0]), .load(ld[2]), .busy(busy_w[2]),
    .done(done_w[2]), .overflow(ovf_w[2]), .bcd(bcd7), .segments(seg7w));
  bcd_display_driver #(.BIN_W(14), .DIGITS(4), .BLANK_LEADING(1)) u14 (
    .clock(clock), .reset(reset), .value(vin), .load(ld[3]), .busy(busy_w[3]),
    .done(done_w[3]), .overflow(ovf_w[3]), .bcd(bcd14), .segments(seg14));

  always_comb begin
    obs_bcd = '0;
    obs_seg = '0;
    case (sel)
      0: begin obs_bcd = 20'(bcd4);  obs_seg = 35'(seg4);  end
      1: begin obs_bcd = 20'(bcd4n); obs_seg = 35'(seg4n); end
      2: begin obs_bcd = 20'(bcd7);  obs_seg = 35'(seg7w); end
      default: begin obs_bcd = 20'(bcd14); obs_seg = 35'(seg14); end
    endcase
    done_s = done_w[sel[1:0]];
    busy_s = busy_w[sel[1:0]];
    ovf_s  = ovf_w[sel[1:0]];
  end

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Decimal digits by division; a digit is blank when the whole value is below its weight.
  function automatic void ref_model(input int v, input int nd, input int bl,
                                    output logic [19:0] eb, output logic [34:0] es,
                                    output logic eo);
    int p;
    int d;
    eo = (v > 10 ** nd - 1);
    eb = '0;
    es = '0;
    p  = 1;
    for (int i = 0; i < nd; i++) begin
      d = eo ? 9 : (v / p) % 10;
      eb[4*i +: 4] = 4'(d);
      if (bl != 0 && !eo && i > 0 && v < p) es[7*i +: 7] = 7'b1111111;
      else es[7*i +: 7] = seg_ref(d);
      p = p * 10;
    end
  endfunction

  // Load v into instance 'which'; returns with the bench #1 after the done edge.
  task automatic do_conv(input int which, input int v, output int lat);
    @(negedge clock);
    sel = which;
    vin = 14'(v);
    ld  = 4'(1 << which);
    @(posedge clock);
    #1;
    ld  = '0;
    vin = 14'($urandom);
    lat = 0;
    while (done_s !== 1'b1 && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic test_model(input int which, input int v);
    int lat;
    logic [19:0] eb;
    logic [34:0] es;
    logic eo;
    ref_model(v, nd_tab[which], bl_tab[which], eb, es, eo);
    do_conv(which, v, lat);
    checks++;
    if (lat !== bw_tab[which] + 1) begin
      errors++;
      $display("FAIL latency w%0d v=%0d: got %0d expected %0d", which, v, lat, bw_tab[which] + 1);
    end
    checks++;
    if ({ovf_s, obs_bcd, obs_seg} !== {eo, eb, es}) begin
      errors++;
      $display("FAIL model w%0d v=%0d: got ovf=%b bcd=%h seg=%h expected ovf=%b bcd=%h seg=%h",
               which, v, ovf_s, obs_bcd, obs_seg, eo, eb, es);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy_w, done_w, ovf_w} !== 12'h000) begin
      errors++;
      $display("FAIL reset_flags: got %h expected 000", {busy_w, done_w, ovf_w});
    end
    checks++;
    if ({bcd4, bcd14} !== 24'h0) begin
      errors++;
      $display("FAIL reset_bcd: got %h expected 000000", {bcd4, bcd14});
    end
    checks++;
    if ({seg4, seg14} !== {42{1'b1}}) begin
      errors++;
      $display("FAIL reset_seg: got %h expected all ones", {seg4, seg14});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    do_conv(0, 13, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL basic_latency: got %0d expected 5", lat);
    end
    checks++;
    if ({ovf_s, busy_s, bcd4, seg4} !== {1'b0, 1'b0, 8'h13, 7'b1111001, 7'b0110000}) begin
      errors++;
      $display("FAIL basic_13: got ovf=%b busy=%b bcd=%h seg=%b", ovf_s, busy_s, bcd4, seg4);
    end
    repeat (3) @(negedge clock);
    checks++;
    if ({done_s, bcd4} !== {1'b0, 8'h13}) begin
      errors++;
      $display("FAIL basic_hold: got done=%b bcd=%h expected done=0 bcd=13", done_s, bcd4);
    end
  endtask

  task automatic test_blank();
    int lat;
    do_conv(0, 5, lat);
    checks++;
    if (seg4 !== {7'b1111111, 7'b0010010}) begin
      errors++;
      $display("FAIL blank_5: got %b expected 11111110010010", seg4);
    end
    do_conv(0, 0, lat);
    checks++;
    if (seg4 !== {7'b1111111, 7'b1000000}) begin
      errors++;
      $display("FAIL blank_0: got %b expected 11111111000000", seg4);
    end
    do_conv(1, 0, lat);
    checks++;
    if (seg4n !== {7'b1000000, 7'b1000000}) begin
      errors++;
      $display("FAIL noblank_0: got %b expected 10000001000000", seg4n);
    end
    for (int i = 0; i < 16; i++) begin
      test_model(0, int'($urandom_range(0, 15)));
      test_model(1, int'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_overflow();
    int lat;
    do_conv(2, 120, lat);
    checks++;
    if ({ovf_s, bcd7, seg7w} !== {1'b1, 8'h99, 7'b0010000, 7'b0010000}) begin
      errors++;
      $display("FAIL ovf_120: got ovf=%b bcd=%h seg=%b", ovf_s, bcd7, seg7w);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold: got %b expected 1", ovf_s);
    end
    do_conv(2, 42, lat);
    checks++;
    if ({ovf_s, bcd7} !== {1'b0, 8'h42}) begin
      errors++;
      $display("FAIL ovf_clear_42: got ovf=%b bcd=%h expected ovf=0 bcd=42", ovf_s, bcd7);
    end
    test_model(2, 99);
    test_model(2, 100);
    test_model(2, 127);
    for (int i = 0; i < 30; i++) test_model(2, int'($urandom_range(0, 127)));
  endtask

  task automatic test_back_to_back();
    int pulses;
    int lat;
    pulses = 0;
    sel = 0;
    @(negedge clock);
    vin = 14'd9;
    ld  = 4'b0001;
    // Extra loads land during the shift phase (k=1) and in the done state (k=4).
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      ld  = (k == 1 || k == 4) ? 4'b0001 : 4'b0000;
      vin = 14'd3;
      if (done_w[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (bcd4 !== 8'h09) begin
      errors++;
      $display("FAIL b2b_bcd: got %h expected 09", bcd4);
    end
    do_conv(0, 6, lat);
    checks++;
    if ({lat, bcd4} !== {32'd5, 8'h06}) begin
      errors++;
      $display("FAIL b2b_third: got lat=%0d bcd=%h expected lat=5 bcd=06", lat, bcd4);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    int lat;
    pulses = 0;
    sel = 0;
    @(negedge clock);
    vin = 14'd8;
    ld  = 4'b0001;
    @(negedge clock);
    ld = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy_s, done_s, ovf_s, bcd4, seg4} !== {3'b000, 8'h00, 14'h3fff}) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h seg=%b",
               busy_s, done_s, ovf_s, bcd4, seg4);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done_w[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d done pulses expected 0", pulses);
    end
    do_conv(0, 7, lat);
    checks++;
    if ({bcd4, seg4} !== {8'h07, 7'b1111111, 7'b1111000}) begin
      errors++;
      $display("FAIL reset_after_7: got bcd=%h seg=%b", bcd4, seg4);
    end
  endtask

  task automatic test_wide();
    int lat;
    for (int v = 0; v < 300; v++) test_model(3, v);
    for (int v = 9700; v < 10000; v++) test_model(3, v);
    for (int i = 0; i < 300; i++) test_model(3, int'($urandom_range(0, 16383)));
    test_model(3, 16383);
    do_conv(3, 10000, lat);
    checks++;
    if ({ovf_s, bcd14} !== {1'b1, 16'h9999}) begin
      errors++;
      $display("FAIL wide_10000: got ovf=%b bcd=%h expected ovf=1 bcd=9999", ovf_s, bcd14);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    ld     = '0;
    vin    = '0;
    sel    = 0;
    test_reset();
    test_basic();
    test_blank();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
